dbg_trace_arbiter: RTL and testbench
====================================

// Module: dbg_trace_arbiter
// PURPOSE
//  Merges per-hart debug trace records into the single-record-per-cycle stream read by the simulation monitor.
//  - Sits between the NHARTS core debug ports and the monitor.
//  - Buffers each hart's records in a private FIFO.
//  - Round-robin selects one non-empty FIFO per cycle and drives dbg_valid / dbg_hart_id plus the record fields.
// PARAMETERS
//  NHARTS  4  number of hart inputs, 1..4; dbg_hart_id is 2 bits wide
//  DEPTH   4  entries per hart FIFO, power of 2, >=2
// PORTS
//  clock                  in   1          single clock; all state updates on rising edge
//  reset                  in   1          synchronous, active-high
//  in_valid               in   NHARTS     bit h: hart h presents a record this cycle (no ready; always offered)
//  in_rec                 in   NHARTS*136 hart h record at [h*136 +: 136], dbg_rec_t layout
//  dbg_valid              out  1          output record valid this cycle
//  dbg_hart_id            out  2          source hart of the output record
//  dbg_inst_fetch_req     out  1          record field
//  dbg_inst_fetch_addr    out  32         record field
//  dbg_inst_fetch_ack     out  1          record field
//  dbg_inst_fetch_rddata  out  32         record field
//  dbg_reg_wren           out  1          record field
//  dbg_reg_wraddr         out  5          record field
//  dbg_reg_wrdata         out  64         record field
//  drop_cnt               out  16         total records dropped, all harts (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; FIFOs empty; rr_last = NHARTS-1, so hart 0 wins first; drop_cnt = 0.
//  - Push: on edge k, if in_valid[h] and FIFO h is not full (or is popped on the same edge), the record is written.
//  - Full FIFO with no pop on that edge: the record is dropped; FIFO contents are unchanged.
//  - Arbitration (combinational on FIFO non-empty flags):
//    - Search runs from rr_last+1 upward, wrapping modulo NHARTS; the first non-empty FIFO is granted.
//    - A grant pops that FIFO head on the same edge and sets rr_last = granted hart.
//  - Output register: on each edge, dbg_valid <= any grant; dbg_hart_id and fields <= granted head.
//  - With no grant, dbg_valid <= 0 and the fields hold their previous values.
//  - Latency: record sampled on edge k into an empty FIFO with an uncontested grant -> dbg_valid=1 after edge k+1.
//  - Throughput: exactly one record per cycle whenever any FIFO is non-empty; no backpressure from the monitor.
//  - Push and pop on the same FIFO on the same edge: both occur; count unchanged, pointers wrap modulo DEPTH.
//  - Hart ids >= NHARTS are never emitted.
//  - Reset asserted mid-stream: every buffered record is discarded; dbg_valid is 0 on the cycle after the reset edge.
// CONFIGURATION
//  DBG_TRACE_DROP_CNT_EN
//  - Defined: drop_cnt increments by the number of harts dropping on each edge (0..NHARTS) and saturates at 16'hFFFF.
//  - Not defined: drop_cnt is tied to 0 and no counter logic is built; drops are silent.
// STRUCTURE
//  dbg_trace_pkg:
//  - REC_W = 136.
//  - typedef struct packed dbg_rec_t, MSB->LSB: fetch_req, fetch_addr[31:0], fetch_ack, fetch_rddata[31:0],
//    reg_wren, reg_wraddr[4:0], reg_wrdata[63:0].
//  - Function rr_pick(nonempty, last) returning the granted hart id and a grant flag.
//  Sub-module dbg_trace_fifo:
//  - Parameters: WIDTH, DEPTH.
//  - Ports: push, pop, wdata -> rdata (head, combinational), empty, full.
//  - Instantiated NHARTS times via generate.
// TESTING
//  - Reset: assert reset 3 cycles while in_valid=4'hF -> dbg_valid=0 and all outputs 0 throughout and 1 cycle after.
//  - Single hart: hart 2 pushes fetch_addr=32'h8000_0000 on edge k
//    -> dbg_valid=1, dbg_hart_id=2, addr=32'h8000_0000 after edge k+1.
//  - Fairness: all 4 harts push every cycle for 8 cycles
//    -> dbg_hart_id sequence 0,1,2,3,0,1,2,3; no gaps in dbg_valid.
//  - Overflow, DEPTH=4, 4 harts each pushing 8 records back-to-back:
//    - With DBG_TRACE_DROP_CNT_EN: drop_cnt > 0 and emitted count + drop_cnt = 32.
//    - Without it: drop_cnt stays 0.
//  - Full plus simultaneous pop: fill hart 0 FIFO, then push while it is granted -> new record accepted, not dropped.
//  - Reset mid-stream: reset 1 cycle with 3 records buffered -> none emitted afterwards; next push emits normally.

Source files
------------

// File: rtl/dbg_trace_pkg.sv
// Shared types for the debug trace arbiter: record layout and the round-robin pick helper.
package dbg_trace_pkg;

   localparam int REC_W = 136;

   typedef struct packed {
      logic        fetch_req;
      logic [31:0] fetch_addr;
      logic        fetch_ack;
      logic [31:0] fetch_rddata;
      logic        reg_wren;
      logic [4:0]  reg_wraddr;
      logic [63:0] reg_wrdata;
   } dbg_rec_t;

   typedef struct packed {
      logic       gnt;
      logic [1:0] id;
   } rr_res_t;

   // Bits at or above NHARTS are never set, so a modulo-4 walk visits harts in modulo-NHARTS order.
   function automatic rr_res_t rr_pick(input logic [3:0] nonempty, input logic [1:0] last);
      rr_res_t    res;
      logic [1:0] idx;
      res.gnt = 1'b0;
      res.id  = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!res.gnt && nonempty[idx]) begin
            res.gnt = 1'b1;
            res.id  = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Per-hart record FIFO with a combinational head; a push into a full FIFO is accepted only alongside a pop.
module dbg_trace_fifo
   import dbg_trace_pkg::*;
#(
   parameter int WIDTH = REC_W,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             wr_en_s;
   logic             rd_en_s;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rd_en_s = pop & ~empty;
   assign wr_en_s = push & (~full | rd_en_s);
   assign rdata   = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= (AW+1)'(0);
         rd_ptr_r <= (AW+1)'(0);
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Storage write.
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/dbg_trace_arbiter.sv
// Merges per-hart trace records into one registered record per cycle, round-robin across harts.
// Optional DBG_TRACE_DROP_CNT_EN builds a saturating count of records dropped on full FIFOs.
module dbg_trace_arbiter
   import dbg_trace_pkg::*;
#(
   parameter int NHARTS = 4,
   parameter int DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NHARTS-1:0]       in_valid,
   input  logic [NHARTS*REC_W-1:0] in_rec,
   output logic                    dbg_valid,
   output logic [1:0]              dbg_hart_id,
   output logic                    dbg_inst_fetch_req,
   output logic [31:0]             dbg_inst_fetch_addr,
   output logic                    dbg_inst_fetch_ack,
   output logic [31:0]             dbg_inst_fetch_rddata,
   output logic                    dbg_reg_wren,
   output logic [4:0]              dbg_reg_wraddr,
   output logic [63:0]             dbg_reg_wrdata,
   output logic [15:0]             drop_cnt
);

   logic [3:0] nonempty_s;
   logic [3:0] full_s;
   logic [3:0] push_s;
   logic [3:0] pop_s;
   dbg_rec_t   head_s [4];
   rr_res_t    pick_s;

   logic       valid_r;
   logic [1:0] hart_r;
   logic [1:0] rr_last_r;
   dbg_rec_t   rec_r;

   for (genvar h = 0; h < 4; h++) begin : g_hart
      if (h < NHARTS) begin : g_fifo
         logic empty_s;
         dbg_trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push_s[h]),
            .pop   (pop_s[h]),
            .wdata (in_rec[h*REC_W +: REC_W]),
            .rdata (head_s[h]),
            .empty (empty_s),
            .full  (full_s[h])
         );
         assign nonempty_s[h] = ~empty_s;
         assign push_s[h]     = in_valid[h] & (~full_s[h] | pop_s[h]);
      end else begin : g_tie
         assign nonempty_s[h] = 1'b0;
         assign full_s[h]     = 1'b0;
         assign push_s[h]     = 1'b0;
         assign head_s[h]     = '0;
      end
   end

   assign pick_s = rr_pick(nonempty_s, rr_last_r);

   // One-hot pop of the granted hart.
   always_comb begin
      pop_s = 4'b0000;
      if (pick_s.gnt) begin
         pop_s[pick_s.id] = 1'b1;
      end else begin
         pop_s = 4'b0000;
      end
   end

   // Output record register and round-robin pointer; fields hold when nothing is granted.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_r   <= 1'b0;
         hart_r    <= 2'd0;
         rec_r     <= '0;
         rr_last_r <= 2'(NHARTS - 1);
      end else begin
         valid_r <= pick_s.gnt;
         if (pick_s.gnt) begin
            hart_r    <= pick_s.id;
            rec_r     <= head_s[pick_s.id];
            rr_last_r <= pick_s.id;
         end
      end
   end

   assign dbg_valid             = valid_r;
   assign dbg_hart_id           = hart_r;
   assign dbg_inst_fetch_req    = rec_r.fetch_req;
   assign dbg_inst_fetch_addr   = rec_r.fetch_addr;
   assign dbg_inst_fetch_ack    = rec_r.fetch_ack;
   assign dbg_inst_fetch_rddata = rec_r.fetch_rddata;
   assign dbg_reg_wren          = rec_r.reg_wren;
   assign dbg_reg_wraddr        = rec_r.reg_wraddr;
   assign dbg_reg_wrdata        = rec_r.reg_wrdata;

`ifdef DBG_TRACE_DROP_CNT_EN
   logic [2:0]  drop_num_s;
   logic [16:0] drop_sum_s;
   logic [15:0] drop_cnt_r;

   // A record is dropped when offered but not pushed.
   always_comb begin
      drop_num_s = 3'd0;
      for (int h = 0; h < NHARTS; h++) begin
         drop_num_s = drop_num_s + {2'b00, in_valid[h] & ~push_s[h]};
      end
      drop_sum_s = {1'b0, drop_cnt_r} + {14'd0, drop_num_s};
   end

   // Saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_cnt_r <= 16'h0000;
      end else begin
         drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      end
   end

   assign drop_cnt = drop_cnt_r;
`else
   assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dbg_trace_arbiter.sv
// Directed self-checking bench for dbg_trace_arbiter (NHARTS=4, DEPTH=4).
module tb_dbg_trace_arbiter;
   import dbg_trace_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   in_valid;
   logic [543:0] in_rec;
   logic         dbg_valid;
   logic [1:0]   dbg_hart_id;
   logic         dbg_inst_fetch_req;
   logic [31:0]  dbg_inst_fetch_addr;
   logic         dbg_inst_fetch_ack;
   logic [31:0]  dbg_inst_fetch_rddata;
   logic         dbg_reg_wren;
   logic [4:0]   dbg_reg_wraddr;
   logic [63:0]  dbg_reg_wrdata;
   logic [15:0]  drop_cnt;

   int n_total = 0;
   int n_bad   = 0;

   dbg_trace_arbiter #(.NHARTS(4), .DEPTH(4)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .in_valid              (in_valid),
      .in_rec                (in_rec),
      .dbg_valid             (dbg_valid),
      .dbg_hart_id           (dbg_hart_id),
      .dbg_inst_fetch_req    (dbg_inst_fetch_req),
      .dbg_inst_fetch_addr   (dbg_inst_fetch_addr),
      .dbg_inst_fetch_ack    (dbg_inst_fetch_ack),
      .dbg_inst_fetch_rddata (dbg_inst_fetch_rddata),
      .dbg_reg_wren          (dbg_reg_wren),
      .dbg_reg_wraddr        (dbg_reg_wraddr),
      .dbg_reg_wrdata        (dbg_reg_wrdata),
      .drop_cnt              (drop_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic dbg_rec_t mk_rec(input logic [1:0] h, input logic [31:0] addr);
      dbg_rec_t r;
      r.fetch_req    = 1'b1;
      r.fetch_addr   = addr;
      r.fetch_ack    = addr[0];
      r.fetch_rddata = ~addr;
      r.reg_wren     = 1'b1;
      r.reg_wraddr   = {3'b000, h} ^ addr[4:0];
      r.reg_wrdata   = {addr, ~addr};
      return r;
   endfunction

   task automatic set_rec(input logic [1:0] h, input logic [31:0] addr);
      in_rec[32'(h)*136 +: 136] = mk_rec(h, addr);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   dbg_rec_t    exp_rec;
   int          emitted;
   logic [31:0] last_addr [4];
   logic [31:0] exp_addr;

   initial begin
      reset    = 1'b1;
      in_valid = 4'hF;
      in_rec   = '0;
      for (int h = 0; h < 4; h++) set_rec(2'(h), 32'hDEAD_0000 | 32'(h));

      // reset held with all harts offering
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_valid", 64'(dbg_valid), 64'd0);
         check("rst_id", 64'(dbg_hart_id), 64'd0);
         check("rst_addr", 64'(dbg_inst_fetch_addr), 64'd0);
         check("rst_wrdata", dbg_reg_wrdata, 64'd0);
         check("rst_drop", 64'(drop_cnt), 64'd0);
      end
      reset    = 1'b0;
      in_valid = 4'h0;
      tick();
      check("rst_after_valid", 64'(dbg_valid), 64'd0);
      check("rst_after_addr", 64'(dbg_inst_fetch_addr), 64'd0);

      // single hart latency
      set_rec(2'd2, 32'h8000_0000);
      in_valid = 4'b0100;
      tick();
      check("single_k_valid", 64'(dbg_valid), 64'd0);
      in_valid = 4'h0;
      tick();
      exp_rec = mk_rec(2'd2, 32'h8000_0000);
      check("single_valid", 64'(dbg_valid), 64'd1);
      check("single_id", 64'(dbg_hart_id), 64'd2);
      check("single_addr", 64'(dbg_inst_fetch_addr), 64'h8000_0000);
      check("single_req", 64'(dbg_inst_fetch_req), 64'(exp_rec.fetch_req));
      check("single_ack", 64'(dbg_inst_fetch_ack), 64'(exp_rec.fetch_ack));
      check("single_rddata", 64'(dbg_inst_fetch_rddata), 64'(exp_rec.fetch_rddata));
      check("single_wren", 64'(dbg_reg_wren), 64'(exp_rec.reg_wren));
      check("single_wraddr", 64'(dbg_reg_wraddr), 64'(exp_rec.reg_wraddr));
      check("single_wrdata", dbg_reg_wrdata, exp_rec.reg_wrdata);
      tick();
      check("single_idle", 64'(dbg_valid), 64'd0);
      check("single_hold_addr", 64'(dbg_inst_fetch_addr), 64'h8000_0000);

      // fairness, then overflow drain: all harts push for 8 cycles
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      emitted = 0;
      for (int h = 0; h < 4; h++) last_addr[h] = 32'h0;
      for (int c = 1; c <= 40; c++) begin
         if (c <= 8) begin
            in_valid = 4'hF;
            for (int h = 0; h < 4; h++) set_rec(2'(h), 32'h1000_0000 | (32'(h) << 8) | 32'(c));
         end else begin
            in_valid = 4'h0;
         end
         tick();
         if (c == 1) begin
            check("fair_first_idle", 64'(dbg_valid), 64'd0);
         end else if (c <= 9) begin
            exp_addr = 32'h1000_0000 | (32'((c - 2) % 4) << 8) | 32'((c - 2) / 4 + 1);
            check("fair_valid", 64'(dbg_valid), 64'd1);
            check("fair_id", 64'(dbg_hart_id), 64'((c - 2) % 4));
            check("fair_addr", 64'(dbg_inst_fetch_addr), 64'(exp_addr));
         end
         if (dbg_valid) begin
            emitted++;
            last_addr[dbg_hart_id] = dbg_inst_fetch_addr;
         end
      end
      check("ovf_emitted", 64'(emitted), 64'd23);
      check("full_pop_accept_h0", 64'(last_addr[0]), 64'h1000_0006);
      check("ovf_last_h1", 64'(last_addr[1]), 64'h1000_0107);
      check("ovf_last_h2", 64'(last_addr[2]), 64'h1000_0208);
      check("ovf_last_h3", 64'(last_addr[3]), 64'h1000_0305);
`ifdef DBG_TRACE_DROP_CNT_EN
      check("ovf_drop_cnt", 64'(drop_cnt), 64'd9);
      check("ovf_sum", 64'(emitted + int'(drop_cnt)), 64'd32);
`else
      check("ovf_drop_zero", 64'(drop_cnt), 64'd0);
`endif

      // reset mid-stream with three records buffered
      for (int h = 0; h < 3; h++) set_rec(2'(h), 32'hCAFE_0000 | 32'(h));
      in_valid = 4'b0111;
      tick();
      in_valid = 4'h0;
      reset    = 1'b1;
      tick();
      check("mid_rst_valid", 64'(dbg_valid), 64'd0);
      check("mid_rst_drop", 64'(drop_cnt), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_rst_quiet", 64'(dbg_valid), 64'd0);
      end
      set_rec(2'd3, 32'h4000_0003);
      in_valid = 4'b1000;
      tick();
      in_valid = 4'h0;
      tick();
      check("post_rst_valid", 64'(dbg_valid), 64'd1);
      check("post_rst_id", 64'(dbg_hart_id), 64'd3);
      check("post_rst_addr", 64'(dbg_inst_fetch_addr), 64'h4000_0003);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
